// File: rtl/sprite_pkg.sv
// Shared types, colours, default sprite art and ROM addressing
// for the alien sprite engine.
package sprite_pkg;

  localparam int COLOR_W = 12;
  localparam logic [COLOR_W-1:0] KEY_COLOR = 12'hFFF;

  localparam int DEF_W = 11;
  localparam int DEF_H = 8;
  localparam int DEF_TYPES = 3;

  typedef enum logic [1:0] {
    SQUID   = 2'd0,
    CRAB    = 2'd1,
    OCTOPUS = 2'd2
  } alien_t;

  localparam logic [COLOR_W-1:0] TYPE_COLOR [DEF_TYPES] = '{
    12'h0F0, 12'h0FF, 12'hF0F
  };
  localparam logic [COLOR_W-1:0] EXPL_COLOR = 12'hFA0;

  // Bit [DEF_W-1] of each row is column 0.
  localparam logic [DEF_W-1:0] POSE_ART [DEF_TYPES][2][DEF_H] = '{
    '{
      '{11'b00001110000, 11'b00011111000,
        11'b00111111100, 11'b01101110110,
        11'b11111111111, 11'b00101010100,
        11'b01000000010, 11'b00100000100},
      '{11'b00001110000, 11'b00011111000,
        11'b00111111100, 11'b01101110110,
        11'b11111111111, 11'b00101110100,
        11'b01010001010, 11'b10100000101}
    },
    '{
      '{11'b00100000100, 11'b00010001000,
        11'b00111111100, 11'b01101110110,
        11'b11111111111, 11'b10111111101,
        11'b10100000101, 11'b00011011000},
      '{11'b00100000100, 11'b10010001001,
        11'b10111111101, 11'b11101110111,
        11'b11111111111, 11'b01111111110,
        11'b00100000100, 11'b01000000010}
    },
    '{
      '{11'b00011111000, 11'b01111111110,
        11'b11111111111, 11'b11100100111,
        11'b11111111111, 11'b00110001100,
        11'b01101110110, 11'b11000000011},
      '{11'b00011111000, 11'b01111111110,
        11'b11111111111, 11'b11100100111,
        11'b11111111111, 11'b00111011100,
        11'b01100000110, 11'b00110001100}
    }
  };

  localparam logic [DEF_W-1:0] EXPL_ART [DEF_H] = '{
    11'b00010001000, 11'b10001010001,
    11'b01000000010, 11'b00100000100,
    11'b11000000011, 11'b00100000100,
    11'b01001010010, 11'b10010001001
  };

  // fr == nf selects the shared explosion image.
  function automatic int unsigned rom_addr(
    input int unsigned ty,
    input int unsigned fr,
    input int unsigned r,
    input int unsigned c,
    input int unsigned w,
    input int unsigned h,
    input int unsigned nt,
    input int unsigned nf
  );
    if (fr >= nf)
      return nt * nf * h * w + r * w + c;
    return (ty * nf + fr) * h * w + r * w + c;
  endfunction

endpackage

// File: rtl/sprite_rom_array.sv
// Synchronous sprite ROM: all pose images plus the shared
// explosion image, registered read port.
module sprite_rom_array
  import sprite_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int H  = DEF_H,
  parameter int NT = DEF_TYPES,
  parameter int NF = 2,
  parameter int CW = sprite_pkg::COLOR_W,
  parameter logic [CW-1:0] KEY = sprite_pkg::KEY_COLOR,
  localparam int DEPTH = (NT * NF + 1) * H * W,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [CW-1:0] q
);

  localparam int RI_W = $clog2(DEF_H);
  localparam int BI_W = $clog2(DEF_W);

  function automatic logic [CW-1:0] word(input int unsigned a);
    int unsigned img;
    int unsigned r;
    int unsigned c;
    logic [RI_W-1:0] ri;
    logic [BI_W-1:0] bi;
    logic [1:0] ti;
    logic fi;
    logic [DEF_W-1:0] art;
    logic [CW-1:0] ink;
    img = a / (W * H);
    r = (a / W) % H;
    c = a % W;
    if (r >= DEF_H || c >= DEF_W)
      return KEY;
    ri = RI_W'(r);
    bi = BI_W'(DEF_W - 1 - c);
    if (img >= NT * NF) begin
      art = EXPL_ART[ri];
      ink = CW'(EXPL_COLOR);
    end else begin
      ti = 2'((img / NF) % DEF_TYPES);
      fi = 1'((img % NF) % 2);
      art = POSE_ART[ti][fi][ri];
      ink = CW'(TYPE_COLOR[ti]);
    end
    return art[bi] ? ink : KEY;
  endfunction

  (* rom_style = "block" *)
  logic [CW-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign mem[i] = word(i);
  end

  // Registered read; holds the last word when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (en)
      q <= mem[addr];
  end

endmodule

// File: rtl/alien_sprite_engine.sv
// Pipelined alien sprite pixel source with march animation
// and timed explosion override.
module alien_sprite_engine #(
  parameter int SPRITE_W = sprite_pkg::DEF_W,
  parameter int SPRITE_H = sprite_pkg::DEF_H,
  parameter int NUM_TYPES = sprite_pkg::DEF_TYPES,
  parameter int NUM_FRAMES = 2,
  parameter int ANIM_PERIOD = 30,
  parameter int EXPLODE_TICKS = 15,
  parameter int COLOR_W = sprite_pkg::COLOR_W,
  parameter logic [COLOR_W-1:0] KEY_COLOR = sprite_pkg::KEY_COLOR,
  localparam int TYPE_W =
    (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1,
  localparam int ROW_W =
    (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1,
  localparam int COL_W =
    (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int FRAME_W = $clog2(NUM_FRAMES + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               freeze,
  input  logic               explode,
  input  logic               req_valid,
  input  logic [TYPE_W-1:0]  type_sel,
  input  logic [ROW_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  output logic               pix_valid,
  output logic [COLOR_W-1:0] color_data,
  output logic               opaque,
  output logic [FRAME_W-1:0] anim_frame,
  output logic               exploding
);

  import sprite_pkg::*;

  localparam int DEPTH =
    (NUM_TYPES * NUM_FRAMES + 1) * SPRITE_H * SPRITE_W;
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TICK_W =
    (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam int EXP_W = $clog2(EXPLODE_TICKS + 1);

  typedef enum logic {
    ANIMATE,
    EXPLODE
  } state_t;

  state_t state;
  state_t state_nx;
  logic [FRAME_W-1:0] pose;
  logic [FRAME_W-1:0] pose_nx;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_nx;
  logic [EXP_W-1:0] exp_cnt;
  logic [EXP_W-1:0] exp_nx;
  logic adv;

  assign adv = frame_tick & ~freeze;

  // Next animation state; explode wins over a same-cycle tick.
  always_comb begin
    state_nx = state;
    pose_nx = pose;
    tick_nx = tick_cnt;
    exp_nx = exp_cnt;
    unique case (state)
      ANIMATE: begin
        if (adv) begin
          if (tick_cnt == TICK_W'(ANIM_PERIOD - 1)) begin
            tick_nx = '0;
            if (pose == FRAME_W'(NUM_FRAMES - 1))
              pose_nx = '0;
            else
              pose_nx = pose + 1'b1;
          end else begin
            tick_nx = tick_cnt + 1'b1;
          end
        end
      end
      EXPLODE: begin
        if (adv) begin
          exp_nx = exp_cnt - 1'b1;
          if (exp_cnt == EXP_W'(1)) begin
            state_nx = ANIMATE;
            tick_nx = '0;
          end
        end
      end
      default: state_nx = ANIMATE;
    endcase
    if (explode) begin
      state_nx = EXPLODE;
      exp_nx = EXP_W'(EXPLODE_TICKS);
      pose_nx = pose;
      tick_nx = tick_cnt;
    end
  end

  // Animation state and its registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ANIMATE;
      pose <= '0;
      tick_cnt <= '0;
      exp_cnt <= '0;
      anim_frame <= '0;
      exploding <= 1'b0;
    end else begin
      state <= state_nx;
      pose <= pose_nx;
      tick_cnt <= tick_nx;
      exp_cnt <= exp_nx;
      exploding <= (state_nx == EXPLODE);
      anim_frame <= (state_nx == EXPLODE) ?
        FRAME_W'(NUM_FRAMES) : pose_nx;
    end
  end

  logic in_range;
  logic [ADDR_W-1:0] addr;

  assign in_range = (32'(row) < SPRITE_H) &&
                    (32'(col) < SPRITE_W) &&
                    (32'(type_sel) < NUM_TYPES);

  assign addr = in_range ?
    ADDR_W'(rom_addr(32'(type_sel), 32'(anim_frame),
                     32'(row), 32'(col),
                     SPRITE_W, SPRITE_H,
                     NUM_TYPES, NUM_FRAMES)) :
    '0;

  logic s1_valid;
  logic s1_oor;
  logic [ADDR_W-1:0] s1_addr;

  // Stage 1: capture address, range flag and current pose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_oor <= 1'b0;
      s1_addr <= '0;
    end else begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_oor <= ~in_range;
        s1_addr <= addr;
      end
    end
  end

  logic [COLOR_W-1:0] rom_q;
  logic s2_oor;
  logic s2_hit;

  sprite_rom_array #(
    .W   (SPRITE_W),
    .H   (SPRITE_H),
    .NT  (NUM_TYPES),
    .NF  (NUM_FRAMES),
    .CW  (COLOR_W),
    .KEY (KEY_COLOR)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (s1_valid),
    .addr  (s1_addr),
    .q     (rom_q)
  );

  // Stage 2: response valid plus flags alongside the ROM word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid <= 1'b0;
      s2_oor <= 1'b0;
      s2_hit <= 1'b0;
    end else begin
      pix_valid <= s1_valid;
      if (s1_valid) begin
        s2_oor <= s1_oor;
        s2_hit <= 1'b1;
      end
    end
  end

  assign color_data = s2_oor ? KEY_COLOR : rom_q;
  assign opaque = s2_hit & (color_data != KEY_COLOR);

endmodule

// File: tb/tb_alien_sprite_engine.sv
// Directed bench for alien_sprite_engine: table-driven pixel
// lookups plus animation, explosion and reset sequences.
module tb_alien_sprite_engine;

  import sprite_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic freeze = 1'b0;
  logic explode = 1'b0;
  logic req_valid = 1'b0;
  logic [1:0] type_sel = '0;
  logic [2:0] row = '0;
  logic [3:0] col = '0;
  logic pix_valid;
  logic [11:0] color_data;
  logic opaque;
  logic [1:0] anim_frame;
  logic exploding;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  ty;
    logic [2:0]  r;
    logic [3:0]  c;
    logic [11:0] color;
    logic        opq;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  alien_sprite_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .freeze     (freeze),
    .explode    (explode),
    .req_valid  (req_valid),
    .type_sel   (type_sel),
    .row        (row),
    .col        (col),
    .pix_valid  (pix_valid),
    .color_data (color_data),
    .opaque     (opaque),
    .anim_frame (anim_frame),
    .exploding  (exploding)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_pix(input string name,
                         input logic [11:0] c,
                         input logic o);
    chk({name, ".valid"}, 32'(pix_valid), 32'd1);
    chk({name, ".color"}, 32'(color_data), 32'(c));
    chk({name, ".opaque"}, 32'(opaque), 32'(o));
  endtask

  task automatic chk_anim(input string name,
                          input logic [1:0] f,
                          input logic e);
    chk({name, ".frame"}, 32'(anim_frame), 32'(f));
    chk({name, ".exploding"}, 32'(exploding), 32'(e));
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".valid"}, 32'(pix_valid), 32'd0);
    chk({name, ".color"}, 32'(color_data), 32'd0);
    chk({name, ".opaque"}, 32'(opaque), 32'd0);
    chk_anim(name, 2'd0, 1'b0);
  endtask

  task automatic req(input logic [1:0] t,
                     input logic [2:0] r,
                     input logic [3:0] c);
    req_valid = 1'b1;
    type_sel = t;
    row = r;
    col = c;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) cyc();
    frame_tick = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{SQUID,   3'd4, 4'd0,  12'h0F0, 1'b1};
    tbl[1]  = '{SQUID,   3'd0, 4'd0,  12'hFFF, 1'b0};
    tbl[2]  = '{SQUID,   3'd0, 4'd4,  12'h0F0, 1'b1};
    tbl[3]  = '{SQUID,   3'd3, 4'd3,  12'hFFF, 1'b0};
    tbl[4]  = '{CRAB,    3'd0, 4'd2,  12'h0FF, 1'b1};
    tbl[5]  = '{CRAB,    3'd7, 4'd10, 12'hFFF, 1'b0};
    tbl[6]  = '{CRAB,    3'd5, 4'd0,  12'h0FF, 1'b1};
    tbl[7]  = '{OCTOPUS, 3'd7, 4'd10, 12'hF0F, 1'b1};
    tbl[8]  = '{OCTOPUS, 3'd3, 4'd5,  12'hF0F, 1'b1};
    tbl[9]  = '{OCTOPUS, 3'd5, 4'd0,  12'hFFF, 1'b0};
    tbl[10] = '{SQUID,   3'd2, 4'd15, 12'hFFF, 1'b0};
    tbl[11] = '{CRAB,    3'd0, 4'd11, 12'hFFF, 1'b0};
    tbl[12] = '{2'd3,    3'd4, 4'd0,  12'hFFF, 1'b0};
    tbl[13] = '{SQUID,   3'd7, 4'd8,  12'h0F0, 1'b1};

    // Reset held with requests driven.
    req(SQUID, 3'd4, 3'd0);
    #1;
    chk_zero("rst_async");
    repeat (4) begin
      cyc();
      chk_zero("rst_hold");
    end
    idle();
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("rst_release.valid", 32'(pix_valid), 32'd0);
    end
    chk_anim("rst_release", 2'd0, 1'b0);

    // Back-to-back table lookups, pose 0.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV)
        req(tbl[i].ty, tbl[i].r, tbl[i].c);
      else
        idle();
      cyc();
      if (i > 0)
        chk_pix($sformatf("tbl%0d", i - 1),
                tbl[i - 1].color, tbl[i - 1].opq);
    end
    cyc();
    chk("idle.valid", 32'(pix_valid), 32'd0);
    chk("idle.hold", 32'(color_data), 32'(tbl[NV - 1].color));

    // March: 30 ticks per pose, request on the change uses old pose.
    ticks(29);
    chk_anim("tick29", 2'd0, 1'b0);
    frame_tick = 1'b1;
    req(CRAB, 3'd1, 4'd0);
    cyc();
    frame_tick = 1'b0;
    idle();
    chk_anim("tick30", 2'd1, 1'b0);
    cyc();
    chk_pix("old_pose", 12'hFFF, 1'b0);
    req(CRAB, 3'd1, 4'd0);
    cyc();
    req(OCTOPUS, 3'd7, 4'd2);
    cyc();
    chk_pix("crab_f1", 12'h0FF, 1'b1);
    idle();
    cyc();
    chk_pix("octo_f1", 12'hF0F, 1'b1);
    ticks(29);
    chk_anim("tick59", 2'd1, 1'b0);
    ticks(1);
    chk_anim("wrap", 2'd0, 1'b0);

    // Freeze holds pose and tick count.
    freeze = 1'b1;
    ticks(100);
    chk_anim("frozen", 2'd0, 1'b0);
    freeze = 1'b0;
    ticks(29);
    chk_anim("thaw29", 2'd0, 1'b0);
    ticks(1);
    chk_anim("thaw30", 2'd1, 1'b0);

    // Explosion with a same-cycle tick.
    explode = 1'b1;
    frame_tick = 1'b1;
    cyc();
    explode = 1'b0;
    frame_tick = 1'b0;
    chk_anim("expl_start", 2'd2, 1'b1);
    req(SQUID, 3'd0, 4'd3);
    cyc();
    idle();
    cyc();
    chk_pix("expl_pix", 12'hFA0, 1'b1);
    ticks(14);
    chk_anim("expl14", 2'd2, 1'b1);
    ticks(1);
    chk_anim("expl_end", 2'd1, 1'b0);
    ticks(29);
    chk_anim("post29", 2'd1, 1'b0);
    ticks(1);
    chk_anim("post30", 2'd0, 1'b0);

    // Re-trigger at tick 10 restarts the count, even when frozen.
    explode = 1'b1;
    cyc();
    explode = 1'b0;
    ticks(10);
    freeze = 1'b1;
    explode = 1'b1;
    cyc();
    explode = 1'b0;
    chk_anim("retrig", 2'd2, 1'b1);
    freeze = 1'b0;
    ticks(14);
    chk_anim("retrig14", 2'd2, 1'b1);
    ticks(1);
    chk_anim("retrig_end", 2'd0, 1'b0);

    // Reset during explosion with a request in flight.
    explode = 1'b1;
    cyc();
    explode = 1'b0;
    ticks(5);
    req(SQUID, 3'd4, 4'd0);
    cyc();
    idle();
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    cyc();
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("flush.valid", 32'(pix_valid), 32'd0);
    end
    chk_anim("flush", 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
